// File: rtl/ue14500_pkg.sv
// Shared definitions for the UE14500 program sequencer: core opcodes, the
// sequencer run/halt state, and program-word field helpers.
package ue14500_pkg;

   localparam logic [3:0] I_NOP0 = 4'h0;
   localparam logic [3:0] I_LD   = 4'h1;
   localparam logic [3:0] I_ADD  = 4'h2;
   localparam logic [3:0] I_SUB  = 4'h3;
   localparam logic [3:0] I_ONE  = 4'h4;
   localparam logic [3:0] I_NAND = 4'h5;
   localparam logic [3:0] I_OR   = 4'h6;
   localparam logic [3:0] I_XOR  = 4'h7;
   localparam logic [3:0] I_STO  = 4'h8;
   localparam logic [3:0] I_STOC = 4'h9;
   localparam logic [3:0] I_IEN  = 4'hA;
   localparam logic [3:0] I_OEN  = 4'hB;
   localparam logic [3:0] I_JMP  = 4'hC;
   localparam logic [3:0] I_RTN  = 4'hD;
   localparam logic [3:0] I_SKZ  = 4'hE;
   localparam logic [3:0] I_NOPF = 4'hF;

   typedef enum logic {
      S_RUN,
      S_HALT
   } seq_state_e;

   // Helpers take words zero-extended to a fixed width so any operand width fits.
   localparam int WORD_MAX_W = 64;

   function automatic logic [3:0] word_opcode(input logic [WORD_MAX_W-1:0] word, input int opnd_w);
      return 4'(word >> opnd_w);
   endfunction

   function automatic logic [WORD_MAX_W-1:0] word_operand(input logic [WORD_MAX_W-1:0] word,
                                                          input int opnd_w);
      return word & ((WORD_MAX_W'(1) << opnd_w) - WORD_MAX_W'(1));
   endfunction

endpackage

// File: rtl/ue14500_sequencer_if.sv
// ROM fetch port and core instruction/flag port of the sequencer.
// master = sequencer side, slave = ROM/core side.
interface ue14500_sequencer_if #(
   parameter int PC_W   = 8,
   parameter int OPND_W = 8
);
   logic [PC_W-1:0]     rom_addr;
   logic [OPND_W+3:0]   rom_data;
   logic [3:0]          ir_out;
   logic [OPND_W-1:0]   opnd_out;
   logic                core_jmp;
   logic                core_rtn;

   modport master (
      output rom_addr, ir_out, opnd_out,
      input  rom_data, core_jmp, core_rtn
   );

   modport slave (
      input  rom_addr, ir_out, opnd_out,
      output rom_data, core_jmp, core_rtn
   );
endinterface

// File: rtl/ue14500_retstack.sv
// Return-address LIFO. Push while full and pop while empty are ignored here;
// the sequencer turns them into error flags.
module ue14500_retstack #(
   parameter int  DEPTH  = 4,
   parameter int  DATA_W = 8,
   localparam int SP_W   = $clog2(DEPTH + 1)
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] push_data,
   output logic [DATA_W-1:0] top,
   output logic              full,
   output logic              empty,
   output logic [SP_W-1:0]   sp
);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] mem_q [2**IDX_W];
   logic [SP_W-1:0]   sp_q, sp_d;
   logic              do_push, do_pop;

   assign full    = (sp_q == SP_W'(DEPTH));
   assign empty   = (sp_q == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign top     = mem_q[IDX_W'(sp_q - SP_W'(1))];
   assign sp      = sp_q;

   // NOTE: every combinational output gets a default first, so no latch can be inferred.
   always_comb begin
      sp_d = sp_q;
      if (do_push)
         sp_d = sp_q + SP_W'(1);
      else if (do_pop)
         sp_d = sp_q - SP_W'(1);
   end

   // NOTE: storage has no reset; sp alone decides which entries are meaningful.
   always_ff @(posedge CLK) begin
      if (do_push)
         mem_q[IDX_W'(sp_q)] <= push_data;
   end

   // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         sp_q <= '0;
      else
         sp_q <= sp_d;
   end

endmodule

// File: rtl/ue14500_sequencer.sv
// Program sequencer for the UE14500 1-bit core: fetches ROM words, presents
// opcode/operand, and redirects on core JMP/RTN through the return stack.
module ue14500_sequencer
   import ue14500_pkg::*;
#(
   parameter int  PC_W        = 8,
   parameter int  OPND_W      = 8,
   parameter int  STACK_DEPTH = 4,
   parameter bit  CALL_EN     = 1'b1,
   localparam int SP_W        = $clog2(STACK_DEPTH + 1)
) (
   input  logic                CLK,
   input  logic                RST,
   ue14500_sequencer_if.master bus,
   output logic [SP_W-1:0]     sp,
   output logic                err_ovf,
   output logic                err_unf,
   output logic                halted
);
   seq_state_e        state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [3:0]        ir_q, ir_d;
   logic [OPND_W-1:0] opnd_q, opnd_d;
   logic [OPND_W-1:0] opnd_prev_q, opnd_prev_d;
   logic              err_ovf_q, err_ovf_d;
   logic              err_unf_q, err_unf_d;

   logic              redirect_j, redirect_r;
   logic              push, pop;
   logic              stk_full, stk_empty;
   logic [PC_W-1:0]   stk_top, target, fetch_addr;

   assign halted     = (state_q == S_HALT);
   assign redirect_j = bus.core_jmp & ~halted;
   assign redirect_r = bus.core_rtn & ~bus.core_jmp & ~halted;
   // The jump operand belongs to the instruction before the delay slot.
   assign target     = PC_W'(opnd_prev_q);
   assign push       = CALL_EN & redirect_j;
   assign pop        = redirect_r;

   ue14500_retstack #(
      .DEPTH  (STACK_DEPTH),
      .DATA_W (PC_W)
   ) u_retstack (
      .CLK       (CLK),
      .RST       (RST),
      .push      (push),
      .pop       (pop),
      .push_data (pc_q),
      .top       (stk_top),
      .full      (stk_full),
      .empty     (stk_empty),
      .sp        (sp)
   );

   always_comb begin
      fetch_addr  = pc_q;
      state_d     = state_q;
      pc_d        = pc_q;
      ir_d        = ir_q;
      opnd_d      = opnd_q;
      opnd_prev_d = opnd_prev_q;
      err_ovf_d   = err_ovf_q;
      err_unf_d   = err_unf_q;

      // A call that would overflow, or a return from an empty stack, keeps linear fetch.
      if (redirect_j && !(CALL_EN && stk_full))
         fetch_addr = target;
      else if (redirect_r && !stk_empty)
         fetch_addr = stk_top;

      case (state_q)
         S_RUN: begin
            ir_d        = word_opcode(WORD_MAX_W'(bus.rom_data), OPND_W);
            opnd_d      = OPND_W'(word_operand(WORD_MAX_W'(bus.rom_data), OPND_W));
            opnd_prev_d = opnd_q;
            pc_d        = fetch_addr + PC_W'(1);
            if (push && stk_full) begin
               err_ovf_d = 1'b1;
               state_d   = S_HALT;
            end
            if (pop && stk_empty) begin
               err_unf_d = 1'b1;
               state_d   = S_HALT;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= S_RUN;
         pc_q        <= '0;
         ir_q        <= I_NOPF;
         opnd_q      <= '0;
         opnd_prev_q <= '0;
         err_ovf_q   <= 1'b0;
         err_unf_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         ir_q        <= ir_d;
         opnd_q      <= opnd_d;
         opnd_prev_q <= opnd_prev_d;
         err_ovf_q   <= err_ovf_d;
         err_unf_q   <= err_unf_d;
      end
   end

   assign bus.rom_addr = fetch_addr;
   assign bus.ir_out   = halted ? I_NOP0 : ir_q;
   assign bus.opnd_out = opnd_q;
   assign err_ovf      = err_ovf_q;
   assign err_unf      = err_unf_q;

endmodule

// File: tb/tb_ue14500_sequencer.sv
// Directed bench for ue14500_sequencer: call/return, overflow/underflow halt,
// async reset, plain-jump mode and pc wrap, against a ROM model held in the bench.
module tb_ue14500_sequencer;
   import ue14500_pkg::*;

   localparam int PC_W   = 8;
   localparam int OPND_W = 8;
   localparam int DEPTH  = 4;
   localparam int SP_W   = $clog2(DEPTH + 1);
   localparam int NVEC   = 27;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   int checks   = 0;
   int failures = 0;

   ue14500_sequencer_if #(.PC_W(PC_W), .OPND_W(OPND_W)) a_if ();
   ue14500_sequencer_if #(.PC_W(PC_W), .OPND_W(OPND_W)) b_if ();

   logic [SP_W-1:0] a_sp, b_sp;
   logic a_ovf, a_unf, a_halted, b_ovf, b_unf, b_halted;

   ue14500_sequencer #(
      .PC_W(PC_W), .OPND_W(OPND_W), .STACK_DEPTH(DEPTH), .CALL_EN(1'b1)
   ) u_call (
      .CLK(CLK), .RST(RST), .bus(a_if.master),
      .sp(a_sp), .err_ovf(a_ovf), .err_unf(a_unf), .halted(a_halted)
   );

   ue14500_sequencer #(
      .PC_W(PC_W), .OPND_W(OPND_W), .STACK_DEPTH(DEPTH), .CALL_EN(1'b0)
   ) u_jump (
      .CLK(CLK), .RST(RST), .bus(b_if.master),
      .sp(b_sp), .err_ovf(b_ovf), .err_unf(b_unf), .halted(b_halted)
   );

   // Program: call 0x20 at 3, subroutine returns at 0x21; a chain of calls 5->0x40->...->0x80.
   function automatic logic [OPND_W+3:0] rom_word(input logic [PC_W-1:0] a);
      case (a)
         8'h03:   return {I_JMP, 8'h20};
         8'h05:   return {I_JMP, 8'h40};
         8'h21:   return {I_RTN, 8'hFE};
         8'h40:   return {I_JMP, 8'h50};
         8'h50:   return {I_JMP, 8'h60};
         8'h60:   return {I_JMP, 8'h70};
         8'h70:   return {I_JMP, 8'h80};
         default: return {a[3:0], a};
      endcase
   endfunction

   assign a_if.rom_data = rom_word(a_if.rom_addr);
   assign b_if.rom_data = rom_word(b_if.rom_addr);

   typedef struct {
      logic       rst;
      logic       jmp;
      logic       rtn;
      logic [7:0] addr;
      logic [7:0] ir_addr;
      logic [2:0] sp;
      logic       ovf;
      logic       unf;
   } vec_t;

   vec_t vecs [NVEC];

   localparam logic [7:0] EXP_B [11] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h20, 8'h21,
                                         8'h22, 8'hFE, 8'hFF, 8'h00, 8'h01};

   function automatic vec_t mk(input bit rst, input bit jmp, input bit rtn, input int addr,
                               input int ir_addr, input int sp, input bit ovf, input bit unf);
      vec_t v;
      v.rst     = rst;
      v.jmp     = jmp;
      v.rtn     = rtn;
      v.addr    = 8'(addr);
      v.ir_addr = 8'(ir_addr);
      v.sp      = 3'(sp);
      v.ovf     = ovf;
      v.unf     = unf;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic apply_reset();
      a_if.core_jmp = 1'b0;
      a_if.core_rtn = 1'b0;
      b_if.core_jmp = 1'b0;
      b_if.core_rtn = 1'b0;
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      #1;
   endtask

   task automatic check_vec(input int i, input vec_t v);
      logic [11:0] word;
      logic [3:0]  exp_ir;
      logic [7:0]  exp_opnd;
      logic        halt;
      word     = rom_word(v.ir_addr);
      halt     = v.ovf | v.unf;
      exp_ir   = v.rst ? I_NOPF : (halt ? 4'h0 : word[11:8]);
      exp_opnd = v.rst ? 8'h00 : word[7:0];
      check($sformatf("v%0d rom_addr", i), 32'(a_if.rom_addr), 32'(v.addr));
      check($sformatf("v%0d ir_out", i), 32'(a_if.ir_out), 32'(exp_ir));
      check($sformatf("v%0d opnd_out", i), 32'(a_if.opnd_out), 32'(exp_opnd));
      check($sformatf("v%0d sp", i), 32'(a_sp), 32'(v.sp));
      check($sformatf("v%0d err_ovf", i), 32'(a_ovf), 32'(v.ovf));
      check($sformatf("v%0d err_unf", i), 32'(a_unf), 32'(v.unf));
      check($sformatf("v%0d halted", i), 32'(a_halted), 32'(halt));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      a_if.core_jmp = 1'b0;
      a_if.core_rtn = 1'b0;
      b_if.core_jmp = 1'b0;
      b_if.core_rtn = 1'b0;

      //             rst jmp rtn addr   ir_addr sp ovf unf
      vecs[0]  = mk(1, 0, 0, 'h00, 'h00, 0, 0, 0);
      vecs[1]  = mk(0, 0, 0, 'h01, 'h00, 0, 0, 0);
      vecs[2]  = mk(0, 0, 0, 'h02, 'h01, 0, 0, 0);
      vecs[3]  = mk(0, 0, 0, 'h03, 'h02, 0, 0, 0);
      vecs[4]  = mk(0, 0, 0, 'h04, 'h03, 0, 0, 0);
      vecs[5]  = mk(0, 1, 0, 'h20, 'h04, 0, 0, 0);
      vecs[6]  = mk(0, 0, 0, 'h21, 'h20, 1, 0, 0);
      vecs[7]  = mk(0, 0, 0, 'h22, 'h21, 1, 0, 0);
      vecs[8]  = mk(0, 0, 1, 'h05, 'h22, 1, 0, 0);
      vecs[9]  = mk(0, 0, 0, 'h06, 'h05, 0, 0, 0);
      vecs[10] = mk(0, 1, 0, 'h40, 'h06, 0, 0, 0);
      vecs[11] = mk(0, 0, 0, 'h41, 'h40, 1, 0, 0);
      vecs[12] = mk(0, 1, 0, 'h50, 'h41, 1, 0, 0);
      vecs[13] = mk(0, 0, 0, 'h51, 'h50, 2, 0, 0);
      vecs[14] = mk(0, 1, 0, 'h60, 'h51, 2, 0, 0);
      vecs[15] = mk(0, 0, 0, 'h61, 'h60, 3, 0, 0);
      vecs[16] = mk(0, 1, 0, 'h70, 'h61, 3, 0, 0);
      vecs[17] = mk(0, 0, 0, 'h71, 'h70, 4, 0, 0);
      vecs[18] = mk(0, 1, 0, 'h72, 'h71, 4, 0, 0);
      vecs[19] = mk(0, 0, 0, 'h73, 'h72, 4, 1, 0);
      vecs[20] = mk(0, 1, 0, 'h73, 'h72, 4, 1, 0);
      vecs[21] = mk(0, 0, 1, 'h73, 'h72, 4, 1, 0);
      vecs[22] = mk(1, 0, 0, 'h00, 'h00, 0, 0, 0);
      vecs[23] = mk(0, 0, 1, 'h01, 'h00, 0, 0, 0);
      vecs[24] = mk(0, 0, 0, 'h02, 'h01, 0, 0, 1);
      vecs[25] = mk(0, 1, 0, 'h02, 'h01, 0, 0, 1);
      vecs[26] = mk(1, 0, 0, 'h00, 'h00, 0, 0, 0);

      for (int i = 0; i < NVEC; i++) begin
         if (vecs[i].rst) begin
            apply_reset();
         end else begin
            @(posedge CLK);
            #1;
            a_if.core_jmp = vecs[i].jmp;
            a_if.core_rtn = vecs[i].rtn;
            #1;
         end
         check_vec(i, vecs[i]);
      end

      // Async reset in the middle of a call: clears sp and rom_addr without a clock edge.
      apply_reset();
      for (int e = 1; e <= 6; e++) begin
         @(posedge CLK);
         #1;
         a_if.core_jmp = (e == 5);
      end
      #1;
      check("midcall sp before reset", 32'(a_sp), 32'd1);
      check("midcall rom_addr before reset", 32'(a_if.rom_addr), 32'h21);
      RST = 1'b1;
      #1;
      check("midcall sp in reset", 32'(a_sp), 32'd0);
      check("midcall rom_addr in reset", 32'(a_if.rom_addr), 32'h00);
      check("midcall ir_out in reset", 32'(a_if.ir_out), 32'(I_NOPF));
      check("midcall halted in reset", 32'(a_halted), 32'd0);
      @(negedge CLK);
      RST = 1'b0;
      #1;
      check("midcall rom_addr after release", 32'(a_if.rom_addr), 32'h00);

      // Plain-jump instance: redirect without stack use, then pc wraps 0xFF -> 0x00.
      apply_reset();
      check("jump rom_addr after reset", 32'(b_if.rom_addr), 32'h00);
      for (int e = 1; e <= 11; e++) begin
         @(posedge CLK);
         #1;
         b_if.core_jmp = (e == 5 || e == 8);
         #1;
         check($sformatf("jump e%0d rom_addr", e), 32'(b_if.rom_addr), 32'(EXP_B[e-1]));
         check($sformatf("jump e%0d sp", e), 32'(b_sp), 32'd0);
      end
      check("jump halted", 32'(b_halted), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
